display_page_scheduler: RTL and testbench

DISPLAY_PAGE_SCHEDULER -- requirements
Module: display_page_scheduler

---
 rtl/display_pkg.sv | 32 +++
 rtl/display_page_scheduler_if.sv | 25 ++
 rtl/scan_tick_gen.sv | 39 +++
 rtl/display_page_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_display_page_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared encodings for the display page scheduler: FSM states, right-field
// page codes, warning codes and the page rotation helper.
package display_pkg;

    typedef logic [1:0] page_t;
    typedef logic [1:0] warn_t;

    typedef struct packed {
        logic fuel;
        logic temp;
    } warn_flags_t;

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_CYCLE  = 2'd1;
    localparam logic [1:0] ST_WARN   = 2'd2;
    localparam logic [1:0] ST_ACKED  = 2'd3;

    localparam page_t PAGE_SPEED = 2'd0;
    localparam page_t PAGE_TEMP  = 2'd1;
    localparam page_t PAGE_FUEL  = 2'd2;
    localparam page_t PAGE_RPM   = 2'd3;

    localparam warn_t WARN_NONE = 2'd0;
    localparam warn_t WARN_FUEL = 2'd1;
    localparam warn_t WARN_TEMP = 2'd2;

    // Auto-cycle order skips the speed page: temp -> fuel -> rpm -> temp.
    function automatic page_t next_page(input page_t p);
        return (p == PAGE_RPM) ? PAGE_TEMP : page_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/display_page_scheduler_if.sv
// Sensor/button inputs and display-control outputs of the page scheduler.
interface display_page_scheduler_if;

    logic                tick_1ms;
    logic                obd_mode_sw;
    logic                page_btn;
    logic [7:0]          fuel;
    logic [7:0]          temp;

    logic                tick_scan;
    display_pkg::page_t  page_sel;
    logic                blank_en;
    display_pkg::warn_t  warn_code;

    modport master (
        output tick_1ms, obd_mode_sw, page_btn, fuel, temp,
        input  tick_scan, page_sel, blank_en, warn_code
    );

    modport slave (
        input  tick_1ms, obd_mode_sw, page_btn, fuel, temp,
        output tick_scan, page_sel, blank_en, warn_code
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, first tick on
// the SCAN_DIV-th clock after reset release.
module scan_tick_gen #(
    parameter int SCAN_DIV = 10000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    // Wrap the counter at the terminal count and strobe on that same cycle.
    always_comb begin
        cnt_d  = cnt_q + 16'd1;
        tick_d = 1'b0;
        if (cnt_q == DIV_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Divider state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/display_page_scheduler.sv
// Dashboard page scheduler: picks the right-field page, blinks the display on
// fuel/temperature warnings and generates the digit-scan strobe.
//
//   state  | meaning
//   NORMAL | speed page, no warning
//   CYCLE  | OBD auto-cycle through temp/fuel/rpm pages
//   WARN   | warning active, forced page, display blinking
//   ACKED  | warning acknowledged, code held, normal paging resumed
module display_page_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 10000,
    parameter int PAGE_HOLD_MS = 2000,
    parameter int BLINK_MS     = 250,
    parameter int FUEL_LOW     = 10,
    parameter int TEMP_HIGH    = 110,
    parameter int HYST         = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    display_page_scheduler_if.slave bus
);

    localparam logic [15:0] HOLD_LAST  = 16'(PAGE_HOLD_MS - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);
    localparam logic [8:0]  FUEL_SET   = 9'(FUEL_LOW);
    localparam logic [8:0]  FUEL_CLR   = 9'(FUEL_LOW + HYST);
    localparam logic [8:0]  TEMP_SET   = 9'(TEMP_HIGH);
    localparam logic [8:0]  TEMP_CLR   = 9'(TEMP_HIGH - HYST);

    logic [1:0]  state_q, state_d;
    page_t       page_q, page_d, page_adv;
    page_t       page_sel_q, page_sel_d;
    warn_t       warn_code_q, warn_code_d, live_code;
    logic [15:0] hold_cnt_q, hold_cnt_d, hold_adv;
    logic [15:0] blink_cnt_q, blink_cnt_d, blink_adv;
    logic        blank_q, blank_d, blank_adv;
    logic        btn_q, btn_d;
    logic        btn_rise, any_flag, new_flag;
    warn_flags_t flags_q, flags_d;
    warn_flags_t ack_q, ack_d;
    logic [8:0]  fuel_9, temp_9;
    logic        tick_scan;

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk (clk),
        .rst (rst),
        .tick(tick_scan)
    );

    // Warning flags with hysteresis; 9-bit compares keep FUEL_LOW+HYST from wrapping.
    always_comb begin
        fuel_9       = {1'b0, bus.fuel};
        temp_9       = {1'b0, bus.temp};
        flags_d      = flags_q;
        flags_d.fuel = flags_q.fuel ? (fuel_9 < FUEL_CLR) : (fuel_9 < FUEL_SET);
        flags_d.temp = flags_q.temp ? (temp_9 >= TEMP_CLR) : (temp_9 >= TEMP_SET);
        btn_d        = bus.page_btn;
    end

    // Per-cycle events plus the page and blink updates that apply if the state holds.
    always_comb begin
        btn_rise  = bus.page_btn & ~btn_q;
        any_flag  = flags_q.fuel | flags_q.temp;
        new_flag  = (flags_q.fuel & ~ack_q.fuel) | (flags_q.temp & ~ack_q.temp);
        live_code = flags_q.temp ? WARN_TEMP : WARN_FUEL;

        page_adv = page_q;
        hold_adv = hold_cnt_q;
        if (btn_rise) begin
            page_adv = next_page(page_q);
            hold_adv = '0;
        end else if (bus.tick_1ms) begin
            if (hold_cnt_q == HOLD_LAST) begin
                page_adv = next_page(page_q);
                hold_adv = '0;
            end else begin
                hold_adv = hold_cnt_q + 16'd1;
            end
        end

        blank_adv = blank_q;
        blink_adv = blink_cnt_q;
        if (bus.tick_1ms) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blank_adv = ~blank_q;
                blink_adv = '0;
            end else begin
                blink_adv = blink_cnt_q + 16'd1;
            end
        end
    end

    // State transitions; a raised flag beats the button and page timer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (any_flag)             state_d = ST_WARN;
                else if (bus.obd_mode_sw) state_d = ST_CYCLE;
            end
            ST_CYCLE: begin
                if (any_flag)              state_d = ST_WARN;
                else if (!bus.obd_mode_sw) state_d = ST_NORMAL;
            end
            ST_WARN: begin
                if (!any_flag)     state_d = bus.obd_mode_sw ? ST_CYCLE : ST_NORMAL;
                else if (btn_rise) state_d = ST_ACKED;
            end
            ST_ACKED: begin
                if (!any_flag)     state_d = bus.obd_mode_sw ? ST_CYCLE : ST_NORMAL;
                else if (new_flag) state_d = ST_WARN;
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Page/blink bookkeeping and the next registered output values.
    always_comb begin
        page_d      = page_q;
        hold_cnt_d  = hold_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        ack_d       = ack_q;

        if (state_d != state_q) begin
            // Every state change restarts paging at temp and clears both timers.
            page_d      = PAGE_TEMP;
            hold_cnt_d  = '0;
            blink_cnt_d = '0;
            blank_d     = 1'b0;
            if (state_d == ST_ACKED) ack_d = flags_q;
        end else begin
            case (state_q)
                ST_CYCLE: begin
                    page_d     = page_adv;
                    hold_cnt_d = hold_adv;
                end
                ST_WARN: begin
                    blank_d     = blank_adv;
                    blink_cnt_d = blink_adv;
                end
                ST_ACKED: begin
                    if (bus.obd_mode_sw) begin
                        page_d     = page_adv;
                        hold_cnt_d = hold_adv;
                    end else begin
                        page_d     = PAGE_TEMP;
                        hold_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        page_sel_d  = PAGE_SPEED;
        warn_code_d = WARN_NONE;
        case (state_d)
            ST_CYCLE: page_sel_d = page_d;
            ST_WARN: begin
                page_sel_d  = flags_q.temp ? PAGE_TEMP : PAGE_FUEL;
                warn_code_d = live_code;
            end
            ST_ACKED: begin
                page_sel_d  = bus.obd_mode_sw ? page_d : PAGE_SPEED;
                warn_code_d = (state_q == ST_ACKED) ? warn_code_q : live_code;
            end
            default: ;
        endcase
    end

    // All scheduler state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NORMAL;
            page_q      <= PAGE_SPEED;
            page_sel_q  <= PAGE_SPEED;
            warn_code_q <= WARN_NONE;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
            btn_q       <= 1'b0;
            flags_q     <= '0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            page_sel_q  <= page_sel_d;
            warn_code_q <= warn_code_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
            btn_q       <= btn_d;
            flags_q     <= flags_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.tick_scan = tick_scan;
    assign bus.page_sel  = page_sel_q;
    assign bus.blank_en  = blank_q;
    assign bus.warn_code = warn_code_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Directed bench for display_page_scheduler with a cycle-level reference model.
module tb_display_page_scheduler;

    localparam int SCAN_DIV = 4;
    localparam int HOLD     = 3;
    localparam int BLINK    = 2;
    localparam int FL       = 10;
    localparam int TH       = 110;
    localparam int HY       = 5;

    localparam int M_NORMAL = 0;
    localparam int M_CYCLE  = 1;
    localparam int M_WARN   = 2;
    localparam int M_ACKED  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    display_page_scheduler_if dif();

    display_page_scheduler #(
        .SCAN_DIV    (SCAN_DIV),
        .PAGE_HOLD_MS(HOLD),
        .BLINK_MS    (BLINK),
        .FUEL_LOW    (FL),
        .TEMP_HIGH   (TH),
        .HYST        (HY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode, page shown, ms elapsed, flags with hysteresis.
    int m_mode = M_NORMAL;
    int m_page = 1;
    int m_hold = 0;
    int m_blink_ms = 0;
    int m_code = 0;
    int m_cyc = 0;
    bit m_fw = 0, m_tw = 0, m_ack_fw = 0, m_ack_tw = 0, m_btn_prev = 0;
    int e_page = 0, e_code = 0, e_blank = 0, e_tick = 0;

    task automatic model_step();
        bit press, any_f, nfw, ntw, obd;
        int nmode;
        obd   = dif.obd_mode_sw;
        press = dif.page_btn && !m_btn_prev;
        any_f = m_fw || m_tw;

        m_cyc++;
        e_tick = (m_cyc % SCAN_DIV == 0) ? 1 : 0;

        nfw = m_fw ? (int'(dif.fuel) < FL + HY) : (int'(dif.fuel) < FL);
        ntw = m_tw ? (int'(dif.temp) >= TH - HY) : (int'(dif.temp) >= TH);

        nmode = m_mode;
        case (m_mode)
            M_NORMAL: if (any_f) nmode = M_WARN; else if (obd) nmode = M_CYCLE;
            M_CYCLE:  if (any_f) nmode = M_WARN; else if (!obd) nmode = M_NORMAL;
            M_WARN:   if (!any_f) nmode = obd ? M_CYCLE : M_NORMAL;
                      else if (press) nmode = M_ACKED;
            default:  if (!any_f) nmode = obd ? M_CYCLE : M_NORMAL;
                      else if ((m_fw && !m_ack_fw) || (m_tw && !m_ack_tw)) nmode = M_WARN;
        endcase

        if (nmode != m_mode) begin
            m_page = 1;
            m_hold = 0;
            m_blink_ms = 0;
            if (nmode == M_ACKED) begin
                m_ack_fw = m_fw;
                m_ack_tw = m_tw;
                m_code   = m_tw ? 2 : 1;
            end
        end else if (m_mode == M_CYCLE || (m_mode == M_ACKED && obd)) begin
            if (press) begin
                m_page = m_page % 3 + 1;
                m_hold = 0;
            end else if (dif.tick_1ms) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_page = m_page % 3 + 1;
                    m_hold = 0;
                end
            end
        end else if (m_mode == M_ACKED) begin
            m_page = 1;
            m_hold = 0;
        end else if (m_mode == M_WARN && dif.tick_1ms) begin
            m_blink_ms++;
        end

        case (nmode)
            M_NORMAL: begin e_page = 0; e_code = 0; e_blank = 0; end
            M_CYCLE:  begin e_page = m_page; e_code = 0; e_blank = 0; end
            M_WARN: begin
                e_code  = m_tw ? 2 : 1;
                e_page  = m_tw ? 1 : 2;
                e_blank = (m_blink_ms / BLINK) % 2;
            end
            default: begin e_page = obd ? m_page : 0; e_code = m_code; e_blank = 0; end
        endcase

        m_mode     = nmode;
        m_fw       = nfw;
        m_tw       = ntw;
        m_btn_prev = dif.page_btn;
    endtask

    // Model advances on the same edges as the DUT and clears on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_NORMAL; m_page = 1; m_hold = 0; m_blink_ms = 0; m_code = 0;
            m_cyc = 0; m_fw = 0; m_tw = 0; m_ack_fw = 0; m_ack_tw = 0; m_btn_prev = 0;
            e_page = 0; e_code = 0; e_blank = 0; e_tick = 0;
        end else begin
            model_step();
        end
    end

    // Compare every output against the model on each falling edge out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("tick_scan", int'(dif.tick_scan), e_tick);
            check("page_sel",  int'(dif.page_sel),  e_page);
            check("blank_en",  int'(dif.blank_en),  e_blank);
            check("warn_code", int'(dif.warn_code), e_code);
        end
    end

    task automatic ms_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            dif.tick_1ms = 1'b1;
            @(negedge clk);
            dif.tick_1ms = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press_btn();
        dif.page_btn = 1'b1;
        @(negedge clk);
        dif.page_btn = 1'b0;
    endtask

    task automatic check_outs(input string name, input int pg, input int bl, input int wc);
        check({name, "_page"},  int'(dif.page_sel),  pg);
        check({name, "_blank"}, int'(dif.blank_en),  bl);
        check({name, "_code"},  int'(dif.warn_code), wc);
    endtask

    initial begin
        dif.tick_1ms    = 1'b0;
        dif.obd_mode_sw = 1'b0;
        dif.page_btn    = 1'b0;
        dif.fuel        = 8'd50;
        dif.temp        = 8'd80;
        #12;
        check_outs("reset", 0, 0, 0);
        check("reset_tick", int'(dif.tick_scan), 0);
        rst = 1'b0;

        // Scan strobe on cycles 4, 8, 12 after release.
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            check("scan_lit", int'(dif.tick_scan), (n % 4 == 0) ? 1 : 0);
        end

        // OBD auto-cycle and button advance.
        dif.obd_mode_sw = 1'b1;
        @(negedge clk);
        check("cycle_entry_page", int'(dif.page_sel), 1);
        ms_ticks(2);
        check("cycle_hold_page1", int'(dif.page_sel), 1);
        ms_ticks(1);
        check("cycle_hold_page2", int'(dif.page_sel), 2);
        press_btn();
        check("cycle_btn_page3", int'(dif.page_sel), 3);
        ms_ticks(2);
        check("cycle_restart_page3", int'(dif.page_sel), 3);
        ms_ticks(1);
        check("cycle_wrap_page1", int'(dif.page_sel), 1);
        dif.obd_mode_sw = 1'b0;
        @(negedge clk);
        check("normal_page", int'(dif.page_sel), 0);

        // Low fuel warning, blink, hysteresis, exit.
        dif.fuel = 8'd9;
        @(negedge clk);
        check("fuel_latency_code", int'(dif.warn_code), 0);
        @(negedge clk);
        check_outs("fuel_warn", 2, 0, 1);
        ms_ticks(1);
        check("blink_hold", int'(dif.blank_en), 0);
        ms_ticks(1);
        check("blink_on", int'(dif.blank_en), 1);
        ms_ticks(2);
        check("blink_off", int'(dif.blank_en), 0);
        dif.fuel = 8'd12;
        repeat (3) @(negedge clk);
        check("fuel_hyst_code", int'(dif.warn_code), 1);
        ms_ticks(2);
        check("fuel_hyst_blink", int'(dif.blank_en), 1);
        dif.fuel = 8'd15;
        @(negedge clk);
        check("fuel_exit_latency", int'(dif.warn_code), 1);
        @(negedge clk);
        check_outs("fuel_exit", 0, 0, 0);

        // Simultaneous warnings: overheat wins.
        dif.fuel = 8'd5;
        dif.temp = 8'd120;
        repeat (2) @(negedge clk);
        check_outs("both_warn", 1, 0, 2);
        dif.fuel = 8'd50;
        dif.temp = 8'd80;
        repeat (2) @(negedge clk);
        check_outs("both_exit", 0, 0, 0);

        // Acknowledge fuel warning, page in ACKED, then overheat re-warns.
        dif.fuel = 8'd9;
        repeat (2) @(negedge clk);
        check("ack_pre_code", int'(dif.warn_code), 1);
        ms_ticks(2);
        check("ack_pre_blank", int'(dif.blank_en), 1);
        press_btn();
        check_outs("acked", 0, 0, 1);
        dif.obd_mode_sw = 1'b1;
        @(negedge clk);
        check("acked_obd_page", int'(dif.page_sel), 1);
        ms_ticks(3);
        check("acked_obd_page2", int'(dif.page_sel), 2);
        dif.obd_mode_sw = 1'b0;
        @(negedge clk);
        check_outs("acked_normal", 0, 0, 1);
        dif.temp = 8'd115;
        @(negedge clk);
        check("rewarn_latency", int'(dif.warn_code), 1);
        @(negedge clk);
        check_outs("rewarn", 1, 0, 2);

        // Asynchronous reset mid-blink.
        ms_ticks(2);
        check("pre_rst_blank", int'(dif.blank_en), 1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0);
        check("async_rst_tick", int'(dif.tick_scan), 0);
        dif.fuel = 8'd50;
        dif.temp = 8'd80;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("post_rst", 0, 0, 0);

        // Warning overrides a same-cycle button press in CYCLE; exit restarts at page 1.
        dif.obd_mode_sw = 1'b1;
        @(negedge clk);
        check("ovr_entry_page", int'(dif.page_sel), 1);
        ms_ticks(3);
        check("ovr_page2", int'(dif.page_sel), 2);
        dif.fuel = 8'd9;
        @(negedge clk);
        press_btn();
        check_outs("ovr_warn", 2, 0, 1);
        dif.fuel = 8'd20;
        repeat (2) @(negedge clk);
        check_outs("ovr_exit_cycle", 1, 0, 0);
        dif.obd_mode_sw = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("final_normal", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
